// File: rtl/cle_key_reader.sv
// cle_key_reader: probe-sequence initiator that reads the CLE key device and checks a masked signature
module cle_key_reader #(
   parameter int SEQ_LEN = 8,
   parameter int SETUP   = 1,
   parameter int STROBE  = 2,
   parameter int HOLD    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] seq,
   input  logic [31:0] expect_word,
   input  logic [31:0] mask,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] result,
   output logic        BA13,
   output logic        BA12,
   output logic [3:0]  BA_CMD,
   output logic        BR_W,
   output logic        SSER,
   output logic        KCLK,
   input  logic        KD0,
   input  logic        KD1
);
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_CLK, ST_HOLD, ST_DONE} state_t;
   localparam logic [1:0] SETUP_END  = 2'(SETUP - 1);
   localparam logic [1:0] STROBE_END = 2'(STROBE - 1);
   localparam logic [1:0] HOLD_END   = 2'(HOLD - 1);
   localparam logic [3:0] LAST_IDX   = 4'(SEQ_LEN - 1);
   state_t      state, state_nx;
   logic [1:0]  cnt;
   logic [3:0]  idx;
   logic        phase_end;
   logic [63:0] seq_q;
   logic [31:0] exp_q, mask_q;
   // state register plus phase counter, probe index, latched run parameters and capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         idx    <= '0;
         seq_q  <= '0;
         exp_q  <= '0;
         mask_q <= '0;
         result <= '0;
         pass   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= (state == ST_IDLE || phase_end) ? 2'd0 : cnt + 2'd1;
         if (state == ST_IDLE && start) begin
            seq_q  <= seq;
            exp_q  <= expect_word;
            mask_q <= mask;
            result <= '0;
            pass   <= 1'b0;
            idx    <= '0;
         end
         if (state == ST_STROBE && phase_end)
            result[{idx, 1'b0} +: 2] <= {KD1, KD0};
         if (state == ST_HOLD && phase_end && idx != LAST_IDX)
            idx <= idx + 4'd1;
         if (state == ST_HOLD && phase_end && idx == LAST_IDX)
            pass <= ((result ^ exp_q) & mask_q) == '0;
         if (state == ST_DONE)
            idx <= '0;
      end
   end
   // next-state and bus decode; the address only moves in SETUP/HOLD boundaries while SSER is high
   always_comb begin
      state_nx  = state;
      phase_end = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      BA12      = 1'b1;
      SSER      = 1'b1;
      KCLK      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            BA12 = 1'b0;
            state_nx = start ? ST_SETUP : ST_IDLE;
         end
         ST_SETUP: begin
            phase_end = cnt == SETUP_END;
            state_nx  = phase_end ? ST_STROBE : ST_SETUP;
         end
         ST_STROBE: begin
            SSER      = 1'b0;
            phase_end = cnt == STROBE_END;
            state_nx  = phase_end ? ST_CLK : ST_STROBE;
         end
         ST_CLK: begin
            SSER      = 1'b0;
            KCLK      = 1'b1;
            phase_end = 1'b1;
            state_nx  = ST_HOLD;
         end
         ST_HOLD: begin
            phase_end = cnt == HOLD_END;
            state_nx  = !phase_end ? ST_HOLD : (idx == LAST_IDX) ? ST_DONE : ST_SETUP;
         end
         ST_DONE: begin
            busy      = 1'b0;
            done      = 1'b1;
            BA12      = 1'b0;
            phase_end = 1'b1;
            state_nx  = ST_IDLE;
         end
         default: begin
            busy     = 1'b0;
            BA12     = 1'b0;
            state_nx = ST_IDLE;
         end
      endcase
   end
   assign BA13   = 1'b0;
   assign BR_W   = 1'b1;
   assign BA_CMD = BA12 ? seq_q[{idx, 2'b00} +: 4] : 4'd0;
endmodule

// File: tb/tb_cle_key_reader.sv
// tb_cle_key_reader: directed checks of probe timing, signature compare, start filtering and reset
module tb_cle_key_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start8 = 1'b0;
   logic [63:0] seq_w = '0;
   logic [31:0] exp_w = '0, mask_w = '0;
   logic        kd10 = 1'b1, kd11 = 1'b1;
   logic        busy1, done1, pass1, ba13_1, ba12_1, brw1, sser1, kclk1;
   logic [31:0] result1;
   logic [3:0]  cmd1;
   logic        busy8, done8, pass8, ba13_8, ba12_8, brw8, sser8, kclk8, kd80, kd81;
   logic [31:0] result8;
   logic [3:0]  cmd8;
   logic [7:0]  ks;
   logic        sel8;
   int          total = 0, bad = 0, addr_err = 0, dc = 0, dones = 0;
   logic [31:0] sig_full;

   always #5 clk = ~clk;

   cle_key_reader #(.SEQ_LEN(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .seq(seq_w), .expect_word(exp_w), .mask(mask_w),
      .busy(busy1), .done(done1), .pass(pass1), .result(result1), .BA13(ba13_1), .BA12(ba12_1),
      .BA_CMD(cmd1), .BR_W(brw1), .SSER(sser1), .KCLK(kclk1), .KD0(kd10), .KD1(kd11));

   cle_key_reader #(.SEQ_LEN(8)) u8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .seq(seq_w), .expect_word(exp_w), .mask(mask_w),
      .busy(busy8), .done(done8), .pass(pass8), .result(result8), .BA13(ba13_8), .BA12(ba12_8),
      .BA_CMD(cmd8), .BR_W(brw8), .SSER(sser8), .KCLK(kclk8), .KD0(kd80), .KD1(kd81));

   // behavioural key device: responds while selected in its window, advances on each KCLK
   assign sel8 = !sser8 && ba12_8 && !ba13_8 && brw8;
   assign kd80 = sel8 ? ks[0] ^ cmd8[0] : 1'b1;
   assign kd81 = sel8 ? ks[1] ^ cmd8[1] : 1'b1;
   always @(posedge clk)
      if (start8 && !busy8) ks <= 8'h3C;
      else if (kclk8 && !sser8) ks <= {ks[6:0], ks[7] ^ ks[5]} ^ {4'b0, cmd8};

   function automatic logic [31:0] sig(input logic [63:0] s, input int n);
      logic [7:0] k;
      logic [3:0] c;
      k = 8'h3C;
      sig = '0;
      for (int i = 0; i < n; i++) begin
         c = s[4*i +: 4];
         sig[2*i +: 2] = k[1:0] ^ c[1:0];
         k = {k[6:0], k[7] ^ k[5]} ^ {4'b0, c};
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic run8(input logic [31:0] e, input logic [31:0] m, input int pulse_at);
      logic [3:0] pa;
      exp_w = e;
      mask_w = m;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      dc = 0;
      addr_err = 0;
      pa = 4'd0;
      for (int c = 1; c <= 100; c++) begin
         if (done8) begin
            dc = c;
            break;
         end
         if (!sser8 && cmd8 != pa) addr_err++;
         pa = cmd8;
         start8 = (c == pulse_at);
         @(negedge clk);
      end
      start8 = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_sser", {31'b0, sser8}, 32'd1);
      chk("rst_kclk", {31'b0, kclk8}, 32'd0);
      chk("rst_brw", {31'b0, brw8}, 32'd1);
      chk("rst_addr", {26'b0, ba13_8, ba12_8, cmd8}, 32'd0);
      chk("rst_status", {29'b0, busy8, done8, pass8}, 32'd0);
      chk("rst_result", result8, 32'd0);
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         dones += int'(done8) + int'(done1);
      end
      chk("idle_no_done", dones, 0);

      seq_w = 64'h2;
      kd10 = 1'b0;
      kd11 = 1'b1;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      chk("p1_c1_addr", {27'b0, ba12_1, cmd1}, {27'b0, 1'b1, 4'h2});
      chk("p1_c1_sser_busy", {30'b0, sser1, busy1}, 32'd3);
      @(negedge clk);
      chk("p1_c2_sser", {31'b0, sser1}, 32'd0);
      @(negedge clk);
      chk("p1_c3_sser_kclk", {30'b0, sser1, kclk1}, 32'd0);
      @(negedge clk);
      chk("p1_c4_sser_kclk", {30'b0, sser1, kclk1}, 32'd1);
      chk("p1_c4_addr", {27'b0, ba12_1, cmd1}, {27'b0, 1'b1, 4'h2});
      @(negedge clk);
      chk("p1_c5_sser_kclk", {30'b0, sser1, kclk1}, 32'd2);
      chk("p1_c5_done", {31'b0, done1}, 32'd0);
      @(negedge clk);
      chk("p1_c6_done_busy", {30'b0, done1, busy1}, 32'd2);
      chk("p1_c6_addr", {27'b0, ba12_1, cmd1}, 32'd0);
      chk("p1_result", result1, 32'h2);
      @(negedge clk);
      chk("p1_c7_done", {31'b0, done1}, 32'd0);
      chk("p1_result_hold", result1, 32'h2);

      seq_w = 64'h9A5B_2A5B_9A5B_2A5B;
      sig_full = sig(seq_w, 8);
      run8(sig_full, 32'hFFFF_FFFF, 0);
      chk("full_done_cyc", dc, 41);
      chk("full_pass", {31'b0, pass8}, 32'd1);
      chk("full_result", result8, sig_full);
      chk("full_addr_stable", addr_err, 0);
      chk("full_busy_done", {31'b0, busy8}, 32'd0);

      run8(sig_full ^ 32'h80, 32'hFFFF_FFFF, 0);
      chk("flip7_pass", {31'b0, pass8}, 32'd0);
      chk("flip7_result", result8, sig_full);
      run8(sig_full ^ 32'h80, 32'hFFFF_FF7F, 0);
      chk("mask7_pass", {31'b0, pass8}, 32'd1);

      run8(sig_full, 32'hFFFF_FFFF, 10);
      chk("restart_done_cyc", dc, 41);
      chk("restart_result", result8, sig_full);
      chk("restart_pass", {31'b0, pass8}, 32'd1);
      @(negedge clk);
      chk("restart_idle", {30'b0, busy8, done8}, 32'd0);

      exp_w = sig_full;
      mask_w = 32'hFFFF_FFFF;
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      repeat (11) @(negedge clk);
      chk("c12_sser", {31'b0, sser8}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_sser_kclk", {30'b0, sser8, kclk8}, 32'd2);
      chk("mid_rst_busy", {31'b0, busy8}, 32'd0);
      chk("mid_rst_result", result8, 32'd0);
      chk("mid_rst_addr", {27'b0, ba12_8, cmd8}, 32'd0);
      rst_n = 1'b1;
      dones = 0;
      repeat (50) begin
         @(negedge clk);
         dones += int'(done8);
      end
      chk("mid_rst_no_done", dones, 0);
      run8(sig_full, 32'hFFFF_FFFF, 0);
      chk("after_rst_done_cyc", dc, 41);
      chk("after_rst_pass", {31'b0, pass8}, 32'd1);
      chk("after_rst_result", result8, sig_full);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
